// File: rtl/lsu_axi_lite_if.sv
// Request/response port between the execute stage and the load/store unit,
// and the AXI4-Lite data port between the load/store unit and ram_axi_lite.

interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [2:0]  req_memop;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    // Execute stage side: issues requests, consumes responses.
    modport master (
        output req_valid, req_wen, req_addr, req_memop, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_wen, req_addr, req_memop, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface axi_lite_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/lsu_axi_lite.sv
// Load/store unit: one execute-stage memory request becomes one AXI4-Lite
// read or write on the data port; loads return sign/zero-extended data.

module lsu_axi_lite #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    lsu_req_if.slave          req,
    axi_lite_if.master        axi,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_WR   = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t            r_state;
    logic [2:0]        r_off;
    logic [2:0]        r_memop;
    logic [ADDR_W-1:0] r_awaddr;
    logic [ADDR_W-1:0] r_araddr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wstrb;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic [3:0]        w_nbytes;
    logic              w_req_err;
    logic [ADDR_W-1:0] w_bus_addr;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [7:0]        w_wstrb;
    logic [DATA_W-1:0] w_rdata_sh;
    logic [DATA_W-1:0] w_load_data;
    logic              w_unused;

    assign w_unused = ^req.req_addr[63:ADDR_W];

    // An access is rejected when it would straddle two 8-byte words.
    assign w_nbytes   = 4'd1 << req.req_memop[1:0];
    assign w_req_err  = (req.req_memop == 3'd7) || (({1'b0, req.req_addr[2:0]} + w_nbytes) > 4'd8);
    assign w_bus_addr = {req.req_addr[ADDR_W-1:3], 3'b000};
    assign w_wdata_sh = req.req_wdata << {req.req_addr[2:0], 3'b000};

    always_comb begin
        w_wstrb = 8'h00;
        case (req.req_memop[1:0])
            2'd0:    w_wstrb = 8'h01 << req.req_addr[2:0];
            2'd1:    w_wstrb = 8'h03 << req.req_addr[2:0];
            2'd2:    w_wstrb = 8'h0F << req.req_addr[2:0];
            default: w_wstrb = 8'hFF << req.req_addr[2:0];
        endcase
    end

    assign w_rdata_sh = axi.rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_data = '0;
        case (r_memop)
            3'd0:    w_load_data = {{56{w_rdata_sh[7]}},  w_rdata_sh[7:0]};
            3'd1:    w_load_data = {{48{w_rdata_sh[15]}}, w_rdata_sh[15:0]};
            3'd2:    w_load_data = {{32{w_rdata_sh[31]}}, w_rdata_sh[31:0]};
            3'd3:    w_load_data = w_rdata_sh;
            3'd4:    w_load_data = {56'd0, w_rdata_sh[7:0]};
            3'd5:    w_load_data = {48'd0, w_rdata_sh[15:0]};
            3'd6:    w_load_data = {32'd0, w_rdata_sh[31:0]};
            default: w_load_data = '0;
        endcase
    end

    // Handshakes: a transfer happens on a clock edge where valid and ready are
    // both high; a raised valid holds with stable payload until that edge, and
    // the AW and W channels complete independently of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_off        <= '0;
            r_memop      <= '0;
            r_awaddr     <= '0;
            r_araddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req.req_valid) begin
                        r_off   <= req.req_addr[2:0];
                        r_memop <= req.req_memop;
                        if (w_req_err) begin
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else if (req.req_wen) begin
                            r_awaddr  <= w_bus_addr;
                            r_wdata   <= w_wdata_sh;
                            r_wstrb   <= w_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_araddr  <= w_bus_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (axi.rvalid) begin
                        r_rready     <= 1'b0;
                        r_resp_err   <= |axi.rresp;
                        r_resp_rdata <= (|axi.rresp) ? '0 : w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_WR: begin
                    if (axi.awready) r_awvalid <= 1'b0;
                    if (axi.wready)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || axi.awready) && (!r_wvalid || axi.wready)) begin
                        r_bready <= 1'b1;
                        r_state  <= S_B;
                    end
                end
                S_B: begin
                    if (axi.bvalid) begin
                        r_bready     <= 1'b0;
                        r_resp_err   <= |axi.bresp;
                        r_resp_rdata <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req.req_ready  = (r_state == S_IDLE);
    assign req.resp_valid = r_resp_valid;
    assign req.resp_rdata = r_resp_rdata;
    assign req.resp_err   = r_resp_err;

    assign axi.awaddr  = r_awaddr;
    assign axi.awvalid = r_awvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;
    assign axi.araddr  = r_araddr;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

    assign o_state = r_state;

endmodule

// File: tb/tb_lsu_axi_lite.sv
// Directed vector bench for lsu_axi_lite: the bench plays the execute stage
// and a configurable-wait AXI4-Lite slave.

module tb_lsu_axi_lite;

  logic clk;
  logic rst;
  logic [2:0] dbg_state;

  int total;
  int bad;

  lsu_req_if rq ();
  axi_lite_if #(.ADDR_W(32)) ax ();

  lsu_axi_lite #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (rq),
    .axi     (ax),
    .o_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1);
  end

  typedef struct {
    logic        wen;
    logic [2:0]  memop;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[18];

  // results of the last run_txn
  int          t_lat;
  logic [63:0] t_rdata;
  logic        t_err;
  logic [31:0] t_addr;
  logic [63:0] t_wdata;
  logic [7:0]  t_wstrb;
  logic        t_bus_seen;
  int          t_aw_last;
  int          t_w_last;
  int          t_b_first;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic clear_slave();
    ax.arready = 1'b0;
    ax.rvalid  = 1'b0;
    ax.rdata   = '0;
    ax.rresp   = '0;
    ax.awready = 1'b0;
    ax.wready  = 1'b0;
    ax.bvalid  = 1'b0;
    ax.bresp   = '0;
  endtask

  // driver: issue one request, then act as the slave until resp_valid or budget
  task automatic run_txn(input logic wen, input logic [2:0] memop, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata, input logic [1:0] resp,
                         input int aw_wt, input int w_wt, input int ar_wt, input int r_wt, input int b_wt);
    int aw_c, w_c, ar_c, r_c, b_c, cyc;
    aw_c = 0; w_c = 0; ar_c = 0; r_c = 0; b_c = 0;
    t_lat = -1; t_rdata = '0; t_err = 1'b0; t_addr = '0; t_wdata = '0; t_wstrb = '0;
    t_bus_seen = 1'b0; t_aw_last = -1; t_w_last = -1; t_b_first = -1;
    @(negedge clk);
    rq.req_valid = 1'b1;
    rq.req_wen   = wen;
    rq.req_memop = memop;
    rq.req_addr  = addr;
    rq.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    rq.req_valid = 1'b0;
    rq.req_addr  = 64'($urandom);
    rq.req_wdata = 64'($urandom);
    cyc = 1;
    while (t_lat < 0 && cyc < 40) begin
      clear_slave();
      if (ax.arvalid) begin
        t_bus_seen = 1'b1;
        t_addr = ax.araddr;
        if (ar_c >= ar_wt) ax.arready = 1'b1; else ar_c++;
      end
      if (ax.rready) begin
        if (r_c >= r_wt) begin
          ax.rvalid = 1'b1;
          ax.rdata  = rdata;
          ax.rresp  = resp;
        end else r_c++;
      end
      if (ax.awvalid) begin
        t_bus_seen = 1'b1;
        t_addr = ax.awaddr;
        t_aw_last = cyc;
        if (aw_c >= aw_wt) ax.awready = 1'b1; else aw_c++;
      end
      if (ax.wvalid) begin
        t_bus_seen = 1'b1;
        t_wdata = ax.wdata;
        t_wstrb = ax.wstrb;
        t_w_last = cyc;
        if (w_c >= w_wt) ax.wready = 1'b1; else w_c++;
      end
      if (ax.bready) begin
        if (t_b_first < 0) t_b_first = cyc;
        if (b_c >= b_wt) begin
          ax.bvalid = 1'b1;
          ax.bresp  = resp;
        end else b_c++;
      end
      if (rq.resp_valid) begin
        t_lat   = cyc;
        t_rdata = rq.resp_rdata;
        t_err   = rq.resp_err;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    clear_slave();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rq.req_valid = 1'b0;
    rq.req_wen   = 1'b0;
    rq.req_memop = '0;
    rq.req_addr  = '0;
    rq.req_wdata = '0;
    clear_slave();

    //           wen   op    addr                    wdata                   rdata                   rsp    exp_addr      exp_wdata               strb   exp_rdata               err   lat
    vecs[0]  = '{1'b0, 3'd3, 64'h0000_0000_8000_0010, 64'h0,                 64'h1122_3344_5566_7788, 2'd0, 32'h8000_0010, 64'h0,                 8'h00, 64'h1122_3344_5566_7788, 1'b0, 3};
    vecs[1]  = '{1'b0, 3'd0, 64'h0000_0000_8000_0005, 64'h0,                 64'h0000_F200_0000_0000, 2'd0, 32'h8000_0000, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 3};
    vecs[2]  = '{1'b0, 3'd4, 64'h0000_0000_8000_0005, 64'h0,                 64'h0000_F200_0000_0000, 2'd0, 32'h8000_0000, 64'h0,                 8'h00, 64'h0000_0000_0000_00F2, 1'b0, 3};
    vecs[3]  = '{1'b1, 3'd2, 64'h0000_0000_8000_0004, 64'h0000_0000_DEAD_BEEF, 64'h0,                 2'd0, 32'h8000_0000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0,                 1'b0, 3};
    vecs[4]  = '{1'b0, 3'd2, 64'h0000_0000_8000_0006, 64'h0,                 64'h0,                 2'd0, 32'h0,         64'h0,                 8'h00, 64'h0,                 1'b1, 1};
    vecs[5]  = '{1'b0, 3'd3, 64'h0000_0000_8000_0018, 64'h0,                 64'hAAAA_5555_AAAA_5555, 2'd2, 32'h8000_0018, 64'h0,                 8'h00, 64'h0,                 1'b1, 3};
    vecs[6]  = '{1'b0, 3'd1, 64'h0000_0000_8000_0002, 64'h0,                 64'h1234_5678_8001_ABCD, 2'd0, 32'h8000_0000, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 3};
    vecs[7]  = '{1'b0, 3'd5, 64'h0000_0000_8000_0002, 64'h0,                 64'h1234_5678_8001_ABCD, 2'd0, 32'h8000_0000, 64'h0,                 8'h00, 64'h0000_0000_0000_8001, 1'b0, 3};
    vecs[8]  = '{1'b0, 3'd2, 64'h0000_0000_8000_0004, 64'h0,                 64'h89AB_CDEF_0000_0000, 2'd0, 32'h8000_0000, 64'h0,                 8'h00, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 3};
    vecs[9]  = '{1'b0, 3'd6, 64'hFFFF_FFFF_8000_0004, 64'h0,                 64'h89AB_CDEF_0000_0000, 2'd0, 32'h8000_0000, 64'h0,                 8'h00, 64'h0000_0000_89AB_CDEF, 1'b0, 3};
    vecs[10] = '{1'b1, 3'd0, 64'h0000_0000_8000_0007, 64'h0000_0000_1234_56AB, 64'h0,                 2'd0, 32'h8000_0000, 64'hAB00_0000_0000_0000, 8'h80, 64'h0,                 1'b0, 3};
    vecs[11] = '{1'b1, 3'd3, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0,                 2'd0, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0,                 1'b0, 3};
    vecs[12] = '{1'b1, 3'd1, 64'h0000_0000_8000_000A, 64'h0000_0000_0000_BEEF, 64'h0,                 2'd0, 32'h8000_0008, 64'h0000_0000_BEEF_0000, 8'h0C, 64'h0,                 1'b0, 3};
    vecs[13] = '{1'b0, 3'd7, 64'h0000_0000_8000_0010, 64'h0,                 64'h0,                 2'd0, 32'h0,         64'h0,                 8'h00, 64'h0,                 1'b1, 1};
    vecs[14] = '{1'b1, 3'd3, 64'h0000_0000_8000_0004, 64'h1111_2222_3333_4444, 64'h0,                 2'd0, 32'h0,         64'h0,                 8'h00, 64'h0,                 1'b1, 1};
    vecs[15] = '{1'b1, 3'd2, 64'h0000_0000_8000_0010, 64'h0000_0000_5566_7788, 64'h0,                 2'd1, 32'h8000_0010, 64'h0000_0000_5566_7788, 8'h0F, 64'h0,                 1'b1, 3};
    vecs[16] = '{1'b0, 3'd1, 64'h0000_0000_8000_0006, 64'h0,                 64'hFF7F_0000_0000_0000, 2'd0, 32'h8000_0000, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_FF7F, 1'b0, 3};
    vecs[17] = '{1'b0, 3'd1, 64'h0000_0000_8000_0007, 64'h0,                 64'h0,                 2'd0, 32'h0,         64'h0,                 8'h00, 64'h0,                 1'b1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_req_ready", rq.req_ready, 1);
    check("rst_resp", {rq.resp_valid, rq.resp_err, rq.resp_rdata}, 0);
    check("rst_valids", {ax.awvalid, ax.wvalid, ax.bready, ax.arvalid, ax.rready}, 0);
    check("rst_bus_payload", {ax.awaddr, ax.araddr, ax.wstrb}, 0);
    check("rst_wdata", ax.wdata, 0);
    check("rst_state", dbg_state, 0);

    // table-driven vectors, zero-wait slave
    for (int i = 0; i < 18; i++) begin
      run_txn(vecs[i].wen, vecs[i].memop, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].resp, 0, 0, 0, 0, 0);
      check($sformatf("v%0d_lat", i), 64'(t_lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_rdata", i), t_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), t_err, vecs[i].exp_err);
      if (vecs[i].exp_lat > 1) check($sformatf("v%0d_addr", i), t_addr, vecs[i].exp_addr);
      if (vecs[i].wen && vecs[i].exp_lat > 1) begin
        check($sformatf("v%0d_wdata", i), t_wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d_wstrb", i), t_wstrb, vecs[i].exp_wstrb);
      end
      if (vecs[i].exp_lat == 1) check($sformatf("v%0d_no_bus", i), t_bus_seen, 0);
      check($sformatf("v%0d_pulse_end", i), rq.resp_valid, 0);
      check($sformatf("v%0d_idle", i), rq.req_ready, 1);
    end

    // store with awready held low three cycles, wready immediate
    run_txn(1'b1, 3'd3, 64'h8000_0020, 64'hCAFE_F00D_1234_5678, 64'h0, 2'd0, 3, 0, 0, 0, 0);
    check("awwait_w_last", 64'(t_w_last), 1);
    check("awwait_aw_last", 64'(t_aw_last), 4);
    check("awwait_b_first", 64'(t_b_first), 5);
    check("awwait_lat", 64'(t_lat), 6);
    check("awwait_wdata", t_wdata, 64'hCAFE_F00D_1234_5678);
    check("awwait_pulse_end", rq.resp_valid, 0);

    // store with wready late, awready immediate
    run_txn(1'b1, 3'd2, 64'h8000_0024, 64'h0000_0000_0BAD_F00D, 64'h0, 2'd0, 0, 2, 0, 0, 1);
    check("wwait_aw_last", 64'(t_aw_last), 1);
    check("wwait_w_last", 64'(t_w_last), 3);
    check("wwait_b_first", 64'(t_b_first), 4);
    check("wwait_lat", 64'(t_lat), 6);
    check("wwait_wstrb", t_wstrb, 8'hF0);

    // load with two AR wait cycles and one R wait cycle
    run_txn(1'b0, 3'd3, 64'h8000_0030, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 2'd0, 0, 0, 2, 1, 0);
    check("ldwait_lat", 64'(t_lat), 6);
    check("ldwait_rdata", t_rdata, 64'h0F0E_0D0C_0B0A_0908);

    // reset asserted while waiting in R
    begin
      int pulses;
      pulses = 0;
      @(negedge clk);
      rq.req_valid = 1'b1;
      rq.req_wen   = 1'b0;
      rq.req_memop = 3'd3;
      rq.req_addr  = 64'h8000_0010;
      @(posedge clk);
      @(negedge clk);
      rq.req_valid = 1'b0;
      check("rstR_arvalid", ax.arvalid, 1);
      ax.arready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ax.arready = 1'b0;
      check("rstR_rready", ax.rready, 1);
      check("rstR_state_r", dbg_state, 2);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rstR_idle", rq.req_ready, 1);
      check("rstR_valids", {ax.awvalid, ax.wvalid, ax.bready, ax.arvalid, ax.rready, rq.resp_valid}, 0);
      repeat (5) begin
        if (rq.resp_valid) pulses++;
        @(posedge clk);
        @(negedge clk);
      end
      check("rstR_no_resp", 64'(pulses), 0);
    end

    // normal load after the mid-operation reset
    run_txn(vecs[0].wen, vecs[0].memop, vecs[0].addr, vecs[0].wdata, vecs[0].rdata, vecs[0].resp, 0, 0, 0, 0, 0);
    check("post_rst_lat", 64'(t_lat), 3);
    check("post_rst_rdata", t_rdata, 64'h1122_3344_5566_7788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_axi_lite.md
# lsu_axi_lite

Load/store unit that turns one data-memory request from the execute stage into a single AXI4-Lite read or write transaction on the data port of `ram_axi_lite`. It sits directly downstream of the ALU: the ALU result is the address, and `R_rs2` is the store data. On the load path it returns sign- or zero-extended data to the register write-back mux. It replaces the combinational `DataMem` path once the core stalls on memory.

## Interface
Parameters:
- `ADDR_W`, 32: AXI address width (`InstAddrBus`).
- `DATA_W`, 64: AXI data width; fixed 64, and `wstrb` is 8 bits wide.

Ports:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, request accepted when `req_valid & req_ready`.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address (ALUres). Bits above `ADDR_W` are ignored.
- `req_memop` in 3: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU. Stores use `memop[1:0]` as the size (0 B, 1 H, 2 W, 3 D). Value 7 is illegal.
- `req_wdata` in 64: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 64: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned, illegal memop, or nonzero `rresp`/`bresp`; valid with `resp_valid`.
- AXI write address: `awaddr` out ADDR_W, `awvalid` out, `awready` in.
- AXI write data: `wdata` out 64, `wstrb` out 8, `wvalid` out, `wready` in.
- AXI write response: `bresp` in 2, `bvalid` in, `bready` out.
- AXI read address: `araddr` out ADDR_W, `arvalid` out, `arready` in.
- AXI read data: `rdata` in 64, `rresp` in 2, `rvalid` in, `rready` out.

## Operation
- States are IDLE, AR, R, WR, B and RESP. `req_ready` = (state == IDLE).
- Accept in IDLE latches addr, memop, wen and wdata.
- Size in bytes: n = 1 << memop[1:0].
- Error check: if memop == 7, or `addr[2:0] + n > 8` (access crosses an 8-byte word), go to RESP with `resp_err` = 1. No bus transaction is issued.
- Bus address = {addr[ADDR_W-1:3], 3'b000}.
- Store data and strobe:
  - `wdata` = req_wdata << (8 × addr[2:0]).
  - `wstrb` = ((1 << n) − 1) << addr[2:0].
- Load path: IDLE → AR with `arvalid` = 1. On `arready`: `arvalid` = 0, go to R with `rready` = 1.
  - On `rvalid`: capture `rdata >> (8 × addr[2:0])`, truncate to n bytes, then sign-extend (memop 0–3) or zero-extend (4–6).
  - Set `err` = (rresp != 0) and go to RESP.
- Store path: IDLE → WR with `awvalid` = `wvalid` = 1.
  - Each valid drops independently after its own handshake; each may complete before, after, or with the other.
  - When both are done, go to B with `bready` = 1. On `bvalid`: `err` = (bresp != 0), go to RESP.
- RESP: `resp_valid` = 1 for exactly one cycle, then IDLE.
- All AXI outputs are registered. A valid, once raised, holds with stable address and data until its ready.
- Reset mid-operation: return to IDLE on the next edge, drop all valids and readies, and emit no response. A slave response still in flight is the slave's concern, because `ram_axi_lite` resets on the same `rst`.

## Timing
- Reset values: `req_ready` = 1 (IDLE).
- All other outputs reset to 0: `resp_valid`, `resp_rdata`, `resp_err`, `awvalid`, `wvalid`, `bready`, `arvalid`, `rready`, `awaddr`, `araddr`, `wdata`, `wstrb`.
- Zero-wait load, with cycle 0 the accept:
  - Cycle 1: `arvalid` & `arready`.
  - Cycle 2: `rvalid` & `rready`.
  - Cycle 3: `resp_valid`.
  - Latency is 3 cycles.
- Zero-wait store:
  - Cycle 1: AW and W handshakes.
  - Cycle 2: B handshake.
  - Cycle 3: `resp_valid`.
- Error response: `resp_valid` in cycle 1.
- Each slave wait cycle adds exactly one cycle of latency.
- `req_*` inputs are ignored outside IDLE. The next request can be accepted in the cycle after `resp_valid`.

## Test plan
- LD, addr 0x80000010, rdata 0x1122334455667788 → `araddr` 0x80000010, `resp_rdata` 0x1122334455667788, `resp_err` 0, `resp_valid` at cycle 3.
- LB, addr 0x80000005, rdata 0x0000F20000000000 → `resp_rdata` 0xFFFFFFFFFFFFFFF2. Same access as LBU → 0x00000000000000F2.
- SW, addr 0x80000004, wdata 0xDEADBEEF → `awaddr` 0x80000000, `wdata` 0xDEADBEEF00000000, `wstrb` 0xF0; `resp_valid` after the B handshake.
- LW, addr 0x80000006 → `resp_err` = 1 at cycle 1; `arvalid` never asserted.
- Store with `awready` held low for 3 cycles and `wready` immediate → `wvalid` drops after cycle 1, `awvalid` holds until cycle 4, `bready` rises in cycle 5, and `resp_valid` pulses once.
- LD with `rresp` = 2'b10 → `resp_err` = 1. Separately, assert `rst` while in R → IDLE next cycle, all valids 0, no `resp_valid`.
